// File: rtl/fpnew_slice_arbiter_pkg.sv
// Shared types and helpers for the fpnew slice arbiter.
// Holds the arbiter state bundle and the minimum-one clog2 helper.
package fpnew_pkg;

  localparam int unsigned ArbIdWidth = 8;

  typedef logic [ArbIdWidth-1:0] arb_id_t;

  typedef struct packed {
    arb_id_t pointer;
    logic    lock;
    arb_id_t grant;
  } arb_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpnew_slice_arbiter_id_fifo.sv
// In-order FIFO of granted requester IDs for the slice arbiter.
// Flush empties it and takes priority over push/pop in the same cycle.
module fpnew_arb_id_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = clog2_min1(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = data_i;
        wr_d        = nxt(wr_q);
      end
      if (pop_ok) begin
        rd_d = nxt(rd_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpnew_slice_arbiter.sv
// Round-robin arbiter sharing one fpnew format slice among NumReq requesters.
// Define FPNEW_SLICE_ARB_ASSERT_EN to compile the protocol assertions.
module fpnew_slice_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RspWidth       = 40,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
  output logic                             slice_valid_o,
  input  logic                             slice_ready_i,
  output logic [ReqWidth-1:0]              slice_data_o,
  output logic                             slice_flush_o,
  input  logic                             slice_rsp_valid_i,
  output logic                             slice_rsp_ready_o,
  input  logic [RspWidth-1:0]              slice_rsp_data_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [RspWidth-1:0]              rsp_data_o,
  output logic                             busy_o
);

  localparam int unsigned IdWidth = clog2_min1(NumReq);

  arb_state_t         state_q, state_d;
  logic [IdWidth-1:0] grant_idx;
  logic [IdWidth-1:0] nxt_ptr;
  logic [IdWidth-1:0] head;
  logic               found;
  logic               hs;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  int                 ptr;

  // Held grant wins over the search so a stalled request never changes.
  always_comb begin
    ptr       = int'(state_q.pointer);
    grant_idx = '0;
    found     = 1'b0;
    if (state_q.lock) begin
      grant_idx = IdWidth'(state_q.grant);
      found     = req_valid_i[grant_idx];
    end else begin
      for (int i = 0; i < int'(NumReq); i++) begin
        if (!found && req_valid_i[IdWidth'((ptr + i) % int'(NumReq))]) begin
          found     = 1'b1;
          grant_idx = IdWidth'((ptr + i) % int'(NumReq));
        end
      end
    end
  end

  assign slice_valid_o = found & ~full & ~flush_i & ~rst_i;
  assign slice_data_o  = slice_valid_o ? req_data_i[grant_idx] : '0;
  assign slice_flush_o = flush_i;
  assign hs            = slice_valid_o & slice_ready_i;
  assign push          = hs;
  assign req_ready_o   = hs ? (NumReq'(1) << grant_idx) : '0;
  assign nxt_ptr       = (grant_idx == IdWidth'(NumReq - 1)) ?
                         '0 : grant_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d.lock = 1'b0;
    end else if (hs) begin
      state_d.lock    = 1'b0;
      state_d.pointer = ArbIdWidth'(nxt_ptr);
    end else if (slice_valid_o) begin
      state_d.lock  = 1'b1;
      state_d.grant = ArbIdWidth'(grant_idx);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  fpnew_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (grant_idx),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // An empty FIFO drains stray results without routing them anywhere.
  assign rsp_valid_o = (slice_rsp_valid_i & ~empty) ?
                       (NumReq'(1) << head) : '0;
  assign rsp_data_o  = slice_rsp_data_i;
  assign slice_rsp_ready_o = ~rst_i & (empty | rsp_ready_i[head]);
  assign pop    = slice_rsp_valid_i & ~empty & rsp_ready_i[head];
  assign busy_o = ~empty | slice_valid_o;

`ifdef FPNEW_SLICE_ARB_ASSERT_EN
  for (genvar g = 0; g < int'(NumReq); g++) begin : g_hold
    a_no_withdraw : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g] && !flush_i) |=> req_valid_i[g]);
  end

  a_grant_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full));

  a_no_rsp_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    !(slice_rsp_valid_i && empty));

  a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (slice_valid_o && !slice_ready_i && !flush_i) |=> $stable(slice_data_o));
`endif

endmodule

// File: tb/tb_fpnew_slice_arbiter.sv
// Directed testbench for fpnew_slice_arbiter (NumReq=4, MaxOutstanding=2).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fpnew_slice_arbiter;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][15:0] req_data;
  logic             slice_valid;
  logic             slice_ready;
  logic [15:0]      slice_data;
  logic             slice_flush;
  logic             srsp_valid;
  logic             srsp_ready;
  logic [7:0]       srsp_data;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_ready;
  logic [7:0]       rsp_data;
  logic             busy;

  int passed = 0;
  int total  = 0;

  fpnew_slice_arbiter #(
    .NumReq         (4),
    .ReqWidth       (16),
    .RspWidth       (8),
    .MaxOutstanding (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_data_i        (req_data),
    .slice_valid_o     (slice_valid),
    .slice_ready_i     (slice_ready),
    .slice_data_o      (slice_data),
    .slice_flush_o     (slice_flush),
    .slice_rsp_valid_i (srsp_valid),
    .slice_rsp_ready_o (srsp_ready),
    .slice_rsp_data_i  (srsp_data),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_data_o        (rsp_data),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    req_valid   = 4'b0;
    slice_ready = 1'b0;
    srsp_valid  = 1'b0;
    srsp_data   = 8'h0;
    rsp_ready   = 4'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 16'h00A0 + 16'(i);

    #1;
    chk("rst_slice_valid", 32'(slice_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_srsp_ready", 32'(srsp_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All requesters valid, slice answers one cycle later
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid   = 4'hF;
      slice_ready = 1'b1;
      rsp_ready   = 4'hF;
      srsp_valid  = (k > 0);
      srsp_data   = 8'h10 + 8'(k);
      #1;
      chk("rr_valid", 32'(slice_valid), 32'd1);
      chk("rr_data", 32'(slice_data), 32'h00A0 + 32'(k % 4));
      chk("rr_ready", 32'(req_ready), 32'd1 << (k % 4));
      if (k > 0) chk("rr_rsp", 32'(rsp_valid), 32'd1 << ((k - 1) % 4));
    end
    @(negedge clk);
    req_valid  = 4'b0;
    srsp_valid = 1'b1;
    srsp_data  = 8'h15;
    #1;
    chk("rr_rsp_last", 32'(rsp_valid), 32'b0001);
    chk("rsp_data", 32'(rsp_data), 32'h15);

    // Pointer is 1; lone requester 3 moves it to 0
    @(negedge clk);
    req_valid  = 4'b1000;
    srsp_valid = 1'b0;
    #1;
    chk("r3_data", 32'(slice_data), 32'h00A3);
    chk("r3_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid  = 4'b0;
    srsp_valid = 1'b1;
    #1;
    chk("r3_rsp", 32'(rsp_valid), 32'b1000);

    // Stall on requester 2, requester 0 joins later
    @(negedge clk);
    srsp_valid  = 1'b0;
    req_valid   = 4'b0100;
    slice_ready = 1'b0;
    #1;
    chk("stall_valid", 32'(slice_valid), 32'd1);
    chk("stall_data0", 32'(slice_data), 32'h00A2);
    chk("stall_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk("stall_data1", 32'(slice_data), 32'h00A2);
    @(negedge clk);
    #1;
    chk("stall_data2", 32'(slice_data), 32'h00A2);
    @(negedge clk);
    slice_ready = 1'b1;
    #1;
    chk("stall_acc_data", 32'(slice_data), 32'h00A2);
    chk("stall_acc_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("after_stall_data", 32'(slice_data), 32'h00A0);
    chk("after_stall_ready", 32'(req_ready), 32'b0001);

    // FIFO full (ids 2,0): no issue, pop does not free a slot same cycle
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("full_valid", 32'(slice_valid), 32'd0);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    @(negedge clk);
    srsp_valid = 1'b1;
    rsp_ready  = 4'hF;
    #1;
    chk("pop_rsp", 32'(rsp_valid), 32'b0100);
    chk("pop_srsp_ready", 32'(srsp_ready), 32'd1);
    chk("pop_no_issue", 32'(slice_valid), 32'd0);

    // Issue resumes; head 0 is not ready for two cycles
    @(negedge clk);
    rsp_ready = 4'b1110;
    #1;
    chk("resume_data", 32'(slice_data), 32'h00A1);
    chk("resume_ready", 32'(req_ready), 32'b0010);
    chk("hold_rsp0", 32'(rsp_valid), 32'b0001);
    chk("hold_srsp0", 32'(srsp_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0;
    #1;
    chk("hold_rsp1", 32'(rsp_valid), 32'b0001);
    chk("hold_srsp1", 32'(srsp_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 4'hF;
    #1;
    chk("release_srsp", 32'(srsp_ready), 32'd1);
    chk("release_rsp", 32'(rsp_valid), 32'b0001);
    @(negedge clk);
    #1;
    chk("last_rsp", 32'(rsp_valid), 32'b0010);
    @(negedge clk);
    srsp_valid = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_srsp_ready", 32'(srsp_ready), 32'd1);

    // Pointer is 2: fill with ids 0 and 1, then flush
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    chk("fill0_data", 32'(slice_data), 32'h00A0);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("fill1_data", 32'(slice_data), 32'h00A1);
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("flush_fwd", 32'(slice_flush), 32'd1);
    chk("flush_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush      = 1'b0;
    req_valid  = 4'b0;
    srsp_valid = 1'b1;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("stray_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_drain", 32'(srsp_ready), 32'd1);

    // Pointer kept at 2 across the flush; then async reset mid-stall
    @(negedge clk);
    srsp_valid  = 1'b0;
    req_valid   = 4'hF;
    slice_ready = 1'b0;
    #1;
    chk("post_flush_data", 32'(slice_data), 32'h00A2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(slice_valid), 32'd0);
    chk("arst_data", 32'(slice_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    slice_ready = 1'b1;
    #1;
    chk("post_rst_data", 32'(slice_data), 32'h00A0);
    chk("post_rst_ready", 32'(req_ready), 32'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
